cb_control_gen: RTL and testbench

- Digital emulator of a chain-of-integrators control-bounded ADC front end.
- Turns a stream of signed width-bit input samples into the N-bit per-clock control-bit stream that the batch/recursion filter consumes.
- Drives the filter's N-bit control input in closed-loop benches, and can be built as an on-chip stimulus source.
- One input sample is held for OSR clocks; the modulator updates every clock.

---
 rtl/cb_control_gen.sv | 149 ++++++++++++++
 tb/tb_cb_control_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cb_control_gen.sv
// Purpose: chain-of-integrators control-bounded ADC emulator producing N control bits per clock.
// Latency: a sample accepted on edge t affects s[0] and out[0] from edge t+1; out is registered.
// Backpressure: in_ready is high in IDLE and for one cycle per OSR-clock slot; a missed slot pulses underrun.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset
//   in_sample  signed input sample, held for OSR clocks once accepted
//   in_valid   in_sample is valid
//   in_ready   sample accepted this cycle when in_valid is also high
//   out        control bits, out[k]=1 means integrator k >= 0
//   out_valid  out holds a live control vector
//   underrun   one-cycle pulse when a sample slot passed without a new sample
//
// Optional build macro: CB_DITHER_EN adds a +/-1 LSB LFSR dither to the first stage drive.
module cb_control_gen #(
  parameter int N          = 3,
  parameter int width      = 16,
  parameter int KAPPA      = 1024,
  parameter int GAIN_SHIFT = 2,
  parameter int OSR        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [width-1:0] in_sample,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N-1:0]            out,
  output logic                    out_valid,
  output logic                    underrun
);

  localparam int CW = (OSR > 2) ? $clog2(OSR) : 1;
  localparam int EW = width + 2;

  // Clamp bounds and feedback magnitude at the extended arithmetic width.
  localparam logic signed [EW-1:0] SMAX = {3'b000, {(width-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {3'b111, {(width-1){1'b0}}};
  localparam logic signed [EW-1:0] KAP  = EW'(KAPPA);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic signed [width-1:0] h;
  logic signed [width-1:0] s      [N];
  logic signed [width-1:0] s_next [N];
  logic signed [EW-1:0]    drv    [N];
  logic signed [EW-1:0]    sum    [N];
  logic                    slot_end;
  logic                    load;

  assign slot_end = (cnt == CW'(OSR-1));

`ifdef CB_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = slot_end;
        load     = slot_end && in_valid;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- integrator chain ----------------
  // Every stage reads the pre-update value of its predecessor, so the whole
  // chain is computed combinationally from current state and registered at once.
  always_comb begin
`ifdef CB_DITHER_EN
    drv[0] = ($signed({{2{h[width-1]}}, h}) >>> GAIN_SHIFT)
           + (lfsr[0] ? EW'(1) : -EW'(1));
`else
    drv[0] = $signed({{2{h[width-1]}}, h}) >>> GAIN_SHIFT;
`endif
    for (int k = 1; k < N; k++) begin
      drv[k] = $signed({{2{s[k-1][width-1]}}, s[k-1]}) >>> GAIN_SHIFT;
    end
    for (int k = 0; k < N; k++) begin
      sum[k] = $signed({{2{s[k][width-1]}}, s[k]}) + drv[k] - (out[k] ? KAP : -KAP);
      if (sum[k] > SMAX)      s_next[k] = SMAX[width-1:0];
      else if (sum[k] < SMIN) s_next[k] = SMIN[width-1:0];
      else                    s_next[k] = sum[k][width-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) s[k] <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (state == RUN) begin
      for (int k = 0; k < N; k++) begin
        s[k]   <= s_next[k];
        out[k] <= ~s_next[k][width-1];
      end
      out_valid <= 1'b1;
    end
  end

  // ---------------- sample slot ----------------
  // The held sample is swapped on the same edge as an integrator update;
  // the update on that edge still sees the old h.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h        <= '0;
      cnt      <= '0;
      underrun <= 1'b0;
    end else begin
      if (load) h <= in_sample;
      if (state == IDLE) begin
        if (load) cnt <= '0;
        underrun <= 1'b0;
      end else begin
        cnt      <= slot_end ? '0 : cnt + CW'(1);
        underrun <= slot_end && !in_valid;
      end
    end
  end

`ifdef CB_DITHER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              lfsr <= 16'hACE1;
    else if (state == RUN) lfsr <= {lfsr[14:0], lfsr_fb};
  end
`endif

endmodule

// File: tb/tb_cb_control_gen.sv
module tb_cb_control_gen;

  localparam int N   = 3;
  localparam int W   = 16;
  localparam int OSR = 8;
  localparam int G   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] in_sample;
  logic                in_valid;
  logic                in_ready_a, ov_a, ur_a;
  logic [N-1:0]        out_a;
  logic                in_ready_b, ov_b, ur_b;
  logic [N-1:0]        out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cb_control_gen dut (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready_a), .out(out_a), .out_valid(ov_a), .underrun(ur_a)
  );

  cb_control_gen #(.KAPPA(1)) dut_sat (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready_b), .out(out_b), .out_valid(ov_b), .underrun(ur_b)
  );

  // ---------------- reference model ----------------
  // Slot bookkeeping is shared (both instances see identical handshakes);
  // integrator values are kept per instance as plain integers.
  int  kap [2] = '{1024, 1};
  bit  m_idle;
  int  m_phase;
  int  m_h;
  bit  m_ov, m_ur;
  int  m_s   [2][N];
  bit  m_out [2][N];
  bit [15:0] m_lfsr;

  function automatic int clamp(int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_phase = 0; m_h = 0; m_ov = 0; m_ur = 0; m_lfsr = 16'hACE1;
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < N; k++) begin m_s[j][k] = 0; m_out[j][k] = 0; end
  endtask

  task automatic model_edge();
    int old [N];
    int d;
    if (m_idle) begin
      m_ur = 0;
      if (in_valid) begin m_h = int'(in_sample); m_phase = 0; m_idle = 0; end
      return;
    end
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < N; k++) old[k] = m_s[j][k];
      for (int k = 0; k < N; k++) begin
        d = (k == 0) ? (m_h >>> G) : (old[k-1] >>> G);
`ifdef CB_DITHER_EN
        if (k == 0) d = d + (m_lfsr[0] ? 1 : -1);
`endif
        m_s[j][k]   = clamp(old[k] + d - (m_out[j][k] ? kap[j] : -kap[j]));
        m_out[j][k] = (m_s[j][k] >= 0);
      end
    end
`ifdef CB_DITHER_EN
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    m_ov = 1;
    if (m_phase == OSR-1) begin
      m_ur = !in_valid;
      if (in_valid) m_h = int'(in_sample);
      m_phase = 0;
    end else begin
      m_ur = 0;
      m_phase = m_phase + 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] ea, eb;
    for (int k = 0; k < N; k++) begin ea[k] = m_out[0][k]; eb[k] = m_out[1][k]; end
    chk("out_a",      32'(out_a),      32'(ea));
    chk("out_valid_a", 32'(ov_a),      32'(m_ov));
    chk("underrun_a", 32'(ur_a),       32'(m_ur));
    chk("in_ready_a", 32'(in_ready_a), 32'(m_idle || m_phase == OSR-1));
    chk("out_b",      32'(out_b),      32'(eb));
    chk("out_valid_b", 32'(ov_b),      32'(m_ov));
    chk("underrun_b", 32'(ur_b),       32'(m_ur));
    chk("in_ready_b", 32'(in_ready_b), 32'(m_idle || m_phase == OSR-1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  bit zexp [7] = '{1, 1, 0, 1, 0, 1, 0};
  int urc, acc;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sample = '0;
    model_reset();
    #1;
    check_all();
    repeat (3) tick();
    rst = 1'b1;

    // idle: integrators frozen, nothing valid
    repeat (3) tick();
    chk("idle_out", 32'(out_a), 32'd0);

    // zero input, then underrun behaviour with in_valid dropped
    in_valid = 1'b1; in_sample = '0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("zero_out0", 32'(out_a[0]), 32'(zexp[i]));
    end
    urc = 0;
    repeat (16) begin tick(); urc += int'(ur_a); end
    chk("underrun_count", 32'(urc), 32'd2);

    // handshake cadence with continuous in_valid
    do_reset();
    in_valid = 1'b1;
    acc = 0;
    repeat (64) begin
      in_sample = W'($urandom);
      if (in_ready_a) acc++;
      tick();
    end
    chk("cadence_accepts", 32'(acc), 32'd8);

    // random valid/sample traffic
    repeat (100) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sample = W'($urandom);
      tick();
    end

    // saturation: KAPPA=1 instance driven full scale
    do_reset();
    in_sample = 16'sh7FFF; in_valid = 1'b1;
    tick();
    repeat (40) begin
      tick();
      chk("sat_out0", 32'(out_b[0]), 32'd1);
    end

    // mid-operation reset at slot phase 5
    do_reset();
    in_valid = 1'b1; in_sample = W'($urandom);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && m_phase != 5; i++) tick();
    chk("midrst_phase", 32'(m_phase), 32'd5);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("midrst_out",      32'(out_a),      32'd0);
    chk("midrst_valid",    32'(ov_a),       32'd0);
    chk("midrst_in_ready", 32'(in_ready_a), 32'd1);
    tick();
    rst = 1'b1;
    in_valid = 1'b1; in_sample = W'($urandom);
    tick();
    in_valid = 1'b0;
    repeat (6) begin
      tick();
      chk("restart_not_ready", 32'(in_ready_a), 32'd0);
    end
    tick();
    chk("restart_ready", 32'(in_ready_a), 32'd1);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
